cla_seq_adder_ctrl: RTL
=======================

Name: cla_seq_adder_ctrl

Overview:
- Sequencing controller that adds WIDTH-bit operands by running one 4-bit carry-lookahead slice over successive cycles, one nibble per cycle, least significant nibble first.
- The carry between nibbles is held in a register.
- Sits between a requester (valid/ready input) and a consumer (valid/ready output), so wide additions reuse the 4-bit CLA datapath instead of replicating it.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4. NIBBLES = WIDTH/4 is derived internally.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  requester presents operands
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in to nibble 0
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of the top nibble
- busy  output  1  high in RUN or DONE

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, nibble index=0, carry register=0.
- States:
  - IDLE
    - in_ready=1.
    - On in_valid&&in_ready: capture a, b, cin into internal registers; index=0; clear sum; go RUN.
  - RUN
    - in_ready=0.
    - Each cycle, slice i=index computes on A[4i+3:4i], B[4i+3:4i] and the carry register:
      - Pj=Aj^Bj, Gj=Aj&Bj.
      - Lookahead carries c1..c4 from G, P and the carry register.
      - sum nibble = P ^ {c3,c2,c1,c0}.
    - The sum nibble is written to sum[4i+3:4i]; carry register <= c4; index++.
    - When index==NIBBLES-1, transition to DONE with cout <= c4.
  - DONE
    - out_valid=1; sum and cout held stable.
    - in_ready=0.
    - On out_ready: go IDLE, out_valid deasserts next cycle.
- Latency:
  - Operand handshake at edge k, so RUN occupies cycles k+1..k+NIBBLES.
  - out_valid is high from after edge k+NIBBLES.
  - Minimum initiation interval is NIBBLES+2 cycles (one IDLE cycle between jobs; no IDLE->DONE bypass).
- Width rules:
  - Pure unsigned modular addition: {cout,sum} = a+b+cin.
  - index is ceil(log2(NIBBLES)) bits, minimum 1.
  - For WIDTH=4: single RUN cycle.
- Boundary conditions:
  - in_valid while busy: ignored; operands are not captured; no queuing.
  - out_ready while not DONE: ignored.
  - out_valid held with out_ready low: sum and cout stay constant indefinitely.
  - rst in any state, including mid-RUN: returns to reset values next cycle; the partial result is discarded; no out_valid is produced for the aborted job.
  - Input a/b/cin changing after capture: no effect on the result.
- busy = (state != IDLE).

Optional Feature:
- Macro: CLA_SEQ_ADD_SUB_EN.
- When defined:
  - Extra input sub (1 bit) is sampled with the operands.
  - If sub=1, the captured B is ~b and the initial carry is 1; cin is ignored.
  - Result is a-b mod 2^WIDTH; cout=1 means no borrow.
- When undefined: no sub port; add only; identical timing either way.

Test Plan:
- WIDTH=16, a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1; out_valid rises 4 cycles after the accept edge.
- a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0. Then a=0x8000, b=0x8000, cin=0 -> sum=0x0000, cout=1.
- Hold out_ready=0 for 6 cycles after out_valid -> sum/cout/out_valid stable, in_ready=0. out_ready=1 -> IDLE next cycle, in_ready=1.
- Assert in_valid with a=0xAAAA during RUN of a 0x0F0F+0x00F1 job -> result 0x1000 unaffected, second request not accepted until in_ready=1.
- Pulse rst in the 2nd RUN cycle -> next cycle state IDLE, sum=0, cout=0, out_valid never asserts for that job.
- With CLA_SEQ_ADD_SUB_EN: sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0. sub=1, a=0x0007, b=0x0005 -> sum=0x0002, cout=1.

Source files
------------

// File: rtl/cla_seq_adder_ctrl.sv
// Sequential WIDTH-bit adder reusing one 4-bit carry-lookahead slice, LSB nibble first.
// Define CLA_SEQ_ADD_SUB_EN to add a 'sub' input for modular subtraction.
module cla_seq_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SEQ_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic [3:0] na;
    logic [3:0] nb;
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;
    logic [3:0] s;

    logic [WIDTH-1:0] b_in;
    logic             c_in;

`ifdef CLA_SEQ_ADD_SUB_EN
    assign b_in = sub ? ~b : b;
    assign c_in = sub ? 1'b1 : cin;
`else
    assign b_in = b;
    assign c_in = cin;
`endif

    always_comb begin
        na = 4'h0;
        nb = 4'h0;
        for (int n = 0; n < NIBBLES; n++) begin
            if (idx == IDX_W'(n)) begin
                na = a_q[4*n +: 4];
                nb = b_q[4*n +: 4];
            end
        end
    end

    // Two-level lookahead: every carry is derived directly from G/P and carry_q.
    always_comb begin
        p    = na ^ nb;
        g    = na & nb;
        c[0] = carry_q;
        c[1] = g[0] | (p[0] & carry_q);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & carry_q);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & carry_q);
        s    = p ^ c[3:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            idx     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b_in;
                        carry_q <= c_in;
                        idx     <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int n = 0; n < NIBBLES; n++) begin
                        if (idx == IDX_W'(n)) sum_q[4*n +: 4] <= s;
                    end
                    carry_q <= c[4];
                    if (idx == LAST) begin
                        cout_q <= c[4];
                        idx    <= '0;
                        state  <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule
